// File: rtl/cpu_vram_port.sv
// cpu_vram_port: CPU-side VRAM register port (VRAMADDR / VRAMRW / VRAMMOD).
// Turns register writes into single VRAM access requests. Each request waits
// for the completion pulse of its zone. VRAMRW writes get one level of
// buffering. After each write the address steps by VMOD.
//
// Build option: define VRAM_PREFETCH_EN to issue prefetch READ accesses into
// RDBUF. With the macro undefined, only writes are issued.
//
// Ports:
//   CLK_24M, nRESET            master clock, async active-low reset
//   REG_SEL/REG_WR/REG_WRDATA  register select (0 addr, 1 rw, 2 mod, 3 none),
//                              write strobe and write data
//   REG_RDDATA                 registered read data (VMOD if REG_SEL=2, else RDBUF)
//   CPU_ADDR/ZONE/RW/WRDATA    access request payload (ZONE 1 = fast VRAM, RW 1 = read)
//   CPU_PENDING                request outstanding
//   SLOW_ACK/FAST_ACK          per-zone completion pulses
//   SLOW_RDDATA/FAST_RDDATA    per-zone read data
//   OVERRUN                    sticky flag, set when a VRAMRW write is dropped
module cpu_vram_port (
    input  logic        CLK_24M,
    input  logic        nRESET,
    input  logic [1:0]  REG_SEL,
    input  logic        REG_WR,
    input  logic [15:0] REG_WRDATA,
    output logic [15:0] REG_RDDATA,
    output logic [14:0] CPU_ADDR,
    output logic        CPU_ZONE,
    output logic        CPU_RW,
    output logic [15:0] CPU_WRDATA,
    output logic        CPU_PENDING,
    input  logic        SLOW_ACK,
    input  logic        FAST_ACK,
    input  logic [15:0] SLOW_RDDATA,
    input  logic [15:0] FAST_RDDATA,
    output logic        OVERRUN
);

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] vaddr_q, vaddr_d;
    logic [DW-1:0] vmod_q, vmod_d;
    logic [DW-1:0] rdbuf_q, rdbuf_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          hold_valid_q, hold_valid_d;
    logic          refetch_q, refetch_d;
    logic [AW-1:0] cpu_addr_q, cpu_addr_d;
    logic          cpu_zone_q, cpu_zone_d;
    logic          cpu_rw_q, cpu_rw_d;
    logic [DW-1:0] cpu_wrdata_q, cpu_wrdata_d;
    logic          cpu_pending_q, cpu_pending_d;
    logic [DW-1:0] reg_rddata_q, reg_rddata_d;
    logic          overrun_q, overrun_d;

    logic wr_addr_c, wr_rw_c, wr_mod_c;
    logic active_c, ack_c, refetch_eff_c, enter_c;

    // State and register file
    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state_q       <= ST_IDLE;
            vaddr_q       <= '0;
            vmod_q        <= '0;
            rdbuf_q       <= '0;
            hold_data_q   <= '0;
            hold_valid_q  <= 1'b0;
            refetch_q     <= 1'b0;
            cpu_addr_q    <= '0;
            cpu_zone_q    <= 1'b0;
            cpu_rw_q      <= 1'b1;
            cpu_wrdata_q  <= '0;
            cpu_pending_q <= 1'b0;
            reg_rddata_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            vmod_q        <= vmod_d;
            rdbuf_q       <= rdbuf_d;
            hold_data_q   <= hold_data_d;
            hold_valid_q  <= hold_valid_d;
            refetch_q     <= refetch_d;
            cpu_addr_q    <= cpu_addr_d;
            cpu_zone_q    <= cpu_zone_d;
            cpu_rw_q      <= cpu_rw_d;
            cpu_wrdata_q  <= cpu_wrdata_d;
            cpu_pending_q <= cpu_pending_d;
            reg_rddata_q  <= reg_rddata_d;
            overrun_q     <= overrun_d;
        end
    end

    // Next-state and register update logic
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        vmod_d        = vmod_q;
        rdbuf_d       = rdbuf_q;
        hold_data_d   = hold_data_q;
        hold_valid_d  = hold_valid_q;
        refetch_d     = refetch_q;
        cpu_addr_d    = cpu_addr_q;
        cpu_zone_d    = cpu_zone_q;
        cpu_rw_d      = cpu_rw_q;
        cpu_wrdata_d  = cpu_wrdata_q;
        overrun_d     = overrun_q;
        enter_c       = 1'b0;

        wr_addr_c = REG_WR && (REG_SEL == 2'd0);
        wr_rw_c   = REG_WR && (REG_SEL == 2'd1);
        wr_mod_c  = REG_WR && (REG_SEL == 2'd2);
        active_c  = (state_q != ST_IDLE);
        // Only the ack of the zone being accessed counts.
        ack_c     = active_c && (cpu_zone_q ? FAST_ACK : SLOW_ACK);

`ifdef VRAM_PREFETCH_EN
        // An address write during an access means the prefetched data is stale.
        refetch_eff_c = refetch_q || (wr_addr_c && active_c);
`else
        refetch_eff_c = refetch_q;
`endif

        if (wr_mod_c) begin
            vmod_d = REG_WRDATA;
        end

        // A register write to VRAMADDR wins over the post-write increment.
        if (wr_addr_c) begin
            vaddr_d = REG_WRDATA;
        end else if (ack_c && (state_q == ST_WRITE)) begin
            vaddr_d = {vaddr_q[15], AW'(vaddr_q[14:0] + vmod_q[14:0])};
        end

        if (ack_c && (state_q == ST_READ)) begin
            rdbuf_d = cpu_zone_q ? FAST_RDDATA : SLOW_RDDATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_rw_c) begin
                    state_d      = ST_WRITE;
                    cpu_wrdata_d = REG_WRDATA;
                    enter_c      = 1'b1;
                end
`ifdef VRAM_PREFETCH_EN
                else if (wr_addr_c) begin
                    state_d = ST_READ;
                    enter_c = 1'b1;
                end
`endif
            end
            default: begin
                refetch_d = refetch_eff_c;
                if (ack_c) begin
                    if (hold_valid_q) begin
                        // Consume the hold first; a same-cycle VRAMRW write refills it.
                        state_d      = ST_WRITE;
                        cpu_wrdata_d = hold_data_q;
                        enter_c      = 1'b1;
                        if (wr_rw_c) begin
                            hold_data_d = REG_WRDATA;
                        end else begin
                            hold_valid_d = 1'b0;
                        end
                    end else if (wr_rw_c) begin
                        state_d      = ST_WRITE;
                        cpu_wrdata_d = REG_WRDATA;
                        enter_c      = 1'b1;
                    end
`ifdef VRAM_PREFETCH_EN
                    else if ((state_q == ST_WRITE) || refetch_eff_c) begin
                        state_d   = ST_READ;
                        refetch_d = 1'b0;
                        enter_c   = 1'b1;
                    end
`endif
                    else begin
                        state_d   = ST_IDLE;
                        refetch_d = 1'b0;
                    end
                end else if (wr_rw_c) begin
                    if (!hold_valid_q) begin
                        hold_data_d  = REG_WRDATA;
                        hold_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase

        // Request payload is captured on entry and held until completion.
        if (enter_c) begin
            cpu_addr_d = vaddr_d[14:0];
            cpu_zone_d = vaddr_d[15];
            cpu_rw_d   = (state_d == ST_READ);
        end

        cpu_pending_d = (state_d != ST_IDLE);
        reg_rddata_d  = (REG_SEL == 2'd2) ? vmod_q : rdbuf_q;
    end

    assign REG_RDDATA  = reg_rddata_q;
    assign CPU_ADDR    = cpu_addr_q;
    assign CPU_ZONE    = cpu_zone_q;
    assign CPU_RW      = cpu_rw_q;
    assign CPU_WRDATA  = cpu_wrdata_q;
    assign CPU_PENDING = cpu_pending_q;
    assign OVERRUN     = overrun_q;

endmodule
